// File: rtl/a2o_wb_pkg.sv
// Shared definitions for the A2O Wishbone/interrupt front end.
//   state_e          : bus-bridge FSM states (IDLE, BUS, RESP)
//   IRQ_*            : bit positions of the SoC interrupts inside irq_out
//   TIMEOUT_DEFAULT  : default number of unacknowledged bus cycles before abort
package a2o_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int IRQ_TMR  = 0;
  localparam int IRQ_EXT  = 1;
  localparam int IRQ_SW   = 2;
  localparam int IRQ_EXTS = 3;
  localparam int IRQ_W    = 4;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/a2o_wb_irq_sync.sv
// One register stage for the SoC interrupt lines heading into the core.
// Levels pass straight through with one cycle of latency; no edge detection.
//   clk     : functional clock
//   rst     : synchronous active-high reset, clears the outputs
//   irq_in  : raw interrupt levels, indexed by the IRQ_* constants
//   irq_out : registered interrupt levels
module a2o_wb_irq_sync
  import a2o_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_in,
  output logic [IRQ_W-1:0] irq_out
);

  logic [IRQ_W-1:0] irq_q;
  logic [IRQ_W-1:0] irq_d;

  always_comb begin
    irq_d = irq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_out = irq_q;

endmodule

// File: rtl/a2o_wb.sv
// A2O core wrapper front end: bridges the core's single-outstanding load/store
// request port onto a Wishbone classic master and registers the SoC interrupts.
//   clk_1x / clk_2x   : functional clock / unused pin-compatibility clock
//   rst               : synchronous active-high reset
//   *Interrupt*       : SoC interrupt levels -> irq_out (one register stage)
//   req_* / rsp_*     : core request port and one-cycle response strobe
//   wb_*              : Wishbone B3 classic master (word addressed)
// TIMEOUT : bus cycles without ack before the access is abandoned with
//           rsp_err=1; 0 disables the timeout.
module a2o_wb
  import a2o_wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_1x,
  input  logic        clk_2x,
  input  logic        rst,
  input  logic        timerInterrupt,
  input  logic        externalInterrupt,
  input  logic        softwareInterrupt,
  input  logic        externalInterruptS,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [3:0]  irq_out,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic [31:0] wb_adr,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_datw,
  input  logic        wb_ack,
  input  logic [31:0] wb_datr
);

  localparam int            CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  // clk_2x and the byte-offset address bits have no function here.
  logic unused_pins;
  assign unused_pins = &{1'b0, clk_2x, req_adr[1:0]};

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             wb_cyc_q,  wb_cyc_d;
  logic [31:0]      wb_adr_q,  wb_adr_d;
  logic             wb_we_q,   wb_we_d;
  logic [3:0]       wb_sel_q,  wb_sel_d;
  logic [31:0]      wb_datw_q, wb_datw_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_cyc_d  = wb_cyc_q;
    wb_adr_d  = wb_adr_q;
    wb_we_d   = wb_we_q;
    wb_sel_d  = wb_sel_q;
    wb_datw_d = wb_datw_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_BUS;
          cnt_d     = '0;
          wb_cyc_d  = 1'b1;
          wb_adr_d  = {2'b00, req_adr[31:2]};
          wb_we_d   = req_we;
          wb_sel_d  = req_sel;
          wb_datw_d = req_we ? req_dat : 32'h0;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so an ack in the expiry cycle completes normally.
        if (wb_ack) begin
          state_d   = ST_RESP;
          wb_cyc_d  = 1'b0;
          rsp_dat_d = wb_we_q ? 32'h0 : wb_datr;
          rsp_err_d = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_d == CNT_LIMIT)) begin
          state_d   = ST_RESP;
          wb_cyc_d  = 1'b0;
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1x) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wb_cyc_q  <= 1'b0;
      wb_adr_q  <= 32'h0;
      wb_we_q   <= 1'b0;
      wb_sel_q  <= 4'h0;
      wb_datw_q <= 32'h0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_cyc_q  <= wb_cyc_d;
      wb_adr_q  <= wb_adr_d;
      wb_we_q   <= wb_we_d;
      wb_sel_q  <= wb_sel_d;
      wb_datw_q <= wb_datw_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_cyc_q;
  assign wb_adr    = wb_adr_q;
  assign wb_we     = wb_we_q;
  assign wb_sel    = wb_sel_q;
  assign wb_datw   = wb_datw_q;

  logic [IRQ_W-1:0] irq_raw;

  always_comb begin
    irq_raw           = '0;
    irq_raw[IRQ_TMR]  = timerInterrupt;
    irq_raw[IRQ_EXT]  = externalInterrupt;
    irq_raw[IRQ_SW]   = softwareInterrupt;
    irq_raw[IRQ_EXTS] = externalInterruptS;
  end

  a2o_wb_irq_sync u_irq_sync (
    .clk     (clk_1x),
    .rst     (rst),
    .irq_in  (irq_raw),
    .irq_out (irq_out)
  );

endmodule

// File: tb/tb_a2o_wb.sv
module tb_a2o_wb;

  localparam int TO = 8;

  logic        clk_1x = 1'b0;
  logic        clk_2x = 1'b0;
  logic        clk_2x_run = 1'b1;
  logic        rst = 1'b1;
  logic        timerInterrupt = 1'b0;
  logic        externalInterrupt = 1'b0;
  logic        softwareInterrupt = 1'b0;
  logic        externalInterruptS = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = 32'h0;
  logic [3:0]  req_sel = 4'h0;
  logic [31:0] req_dat = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [3:0]  irq_out;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_adr;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_datw;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_datr = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_1x = ~clk_1x;
  always #2.5 if (clk_2x_run) clk_2x = ~clk_2x;

  a2o_wb #(.TIMEOUT(TO)) dut (
    .clk_1x             (clk_1x),
    .clk_2x             (clk_2x),
    .rst                (rst),
    .timerInterrupt     (timerInterrupt),
    .externalInterrupt  (externalInterrupt),
    .softwareInterrupt  (softwareInterrupt),
    .externalInterruptS (externalInterruptS),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_adr            (req_adr),
    .req_sel            (req_sel),
    .req_dat            (req_dat),
    .rsp_valid          (rsp_valid),
    .rsp_dat            (rsp_dat),
    .rsp_err            (rsp_err),
    .irq_out            (irq_out),
    .wb_stb             (wb_stb),
    .wb_cyc             (wb_cyc),
    .wb_adr             (wb_adr),
    .wb_we              (wb_we),
    .wb_sel             (wb_sel),
    .wb_datw            (wb_datw),
    .wb_ack             (wb_ack),
    .wb_datr            (wb_datr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_irq(input logic [3:0] v);
    timerInterrupt     = v[0];
    externalInterrupt  = v[1];
    softwareInterrupt  = v[2];
    externalInterruptS = v[3];
  endtask

  // One request/response. The bench plays the slave: it raises ack during the
  // 'delay'-th stb cycle (counting from 0). Reference rule: if delay < TO the
  // access completes with stb high delay+1 cycles, otherwise it is abandoned
  // after TO cycles with an error response.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int delay, input logic [31:0] rdat);
    int          cycles;
    bit          normal;
    bit          unstable;
    logic [31:0] exp_adr;
    logic [31:0] exp_datw;
    logic [31:0] exp_rsp;
    int          exp_cycles;

    normal     = (delay < TO);
    exp_adr    = adr / 4;
    exp_datw   = we ? dat : 32'h0;
    exp_rsp    = (normal && !we) ? rdat : 32'h0;
    exp_cycles = normal ? delay + 1 : TO;

    check("idle_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_sel   = sel;
    req_dat   = dat;
    @(negedge clk_1x);
    req_valid = 1'b0;
    req_dat   = $urandom;
    check("bus_cyc",   {31'h0, wb_cyc},  32'h1);
    check("bus_stb",   {31'h0, wb_stb},  32'h1);
    check("bus_adr",   wb_adr,           exp_adr);
    check("bus_we",    {31'h0, wb_we},   {31'h0, we});
    check("bus_sel",   {28'h0, wb_sel},  {28'h0, sel});
    check("bus_datw",  wb_datw,          exp_datw);
    check("bus_ready", {31'h0, req_ready}, 32'h0);

    cycles   = 0;
    unstable = 1'b0;
    while (wb_stb === 1'b1 && cycles < 50) begin
      if (wb_adr !== exp_adr || wb_datw !== exp_datw || wb_cyc !== 1'b1 || rsp_valid !== 1'b0)
        unstable = 1'b1;
      wb_ack  = (cycles == delay);
      wb_datr = (cycles == delay) ? rdat : $urandom;
      @(negedge clk_1x);
      cycles++;
    end
    wb_ack = 1'b0;
    check("bus_stable", {31'h0, unstable}, 32'h0);
    check("stb_cycles", cycles, exp_cycles);

    check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rsp_err",   {31'h0, rsp_err},   {31'h0, !normal});
    check("rsp_dat",   rsp_dat,            exp_rsp);
    check("rsp_cyc",   {31'h0, wb_cyc},    32'h0);
    check("rsp_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk_1x);
    check("post_valid", {31'h0, rsp_valid}, 32'h0);
    check("post_ready", {31'h0, req_ready}, 32'h1);
    $display("txn we=%0d adr=%h sel=%h delay=%0d -> rsp_dat=%h err=%0d", we, adr, sel, delay, rsp_dat, rsp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] irq_v;
    logic [3:0] irq_prev;

    // Reset.
    repeat (3) @(negedge clk_1x);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_cyc",   {31'h0, wb_cyc},    32'h0);
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk_1x);
    clk_2x_run = 1'b0;
    repeat (3) @(negedge clk_1x);
    check("idle_stb",  {31'h0, wb_stb},    32'h0);
    check("idle_cyc",  {31'h0, wb_cyc},    32'h0);
    check("idle_adr",  wb_adr,             32'h0);
    check("idle_datw", wb_datw,            32'h0);
    check("idle_sel",  {28'h0, wb_sel},    32'h0);
    check("idle_rsp",  rsp_dat,            32'h0);
    check("idle_err",  {31'h0, rsp_err},   32'h0);
    check("idle_irq",  {28'h0, irq_out},   32'h0);
    check("idle_rdy",  {31'h0, req_ready}, 32'h1);
    clk_2x_run = 1'b1;

    // Directed load, store, timeout boundary cases.
    do_txn(1'b0, 32'h4000_0010, 4'hF, 32'h0, 2, 32'hDEAD_BEEF);
    do_txn(1'b1, 32'h0000_0104, 4'h3, 32'h0000_A55A, 0, 32'h1234_5678);
    do_txn(1'b0, 32'h0000_0200, 4'hF, 32'h0, 100, 32'hCAFE_F00D);
    // Stray ack while idle must be ignored.
    wb_ack = 1'b1;
    @(negedge clk_1x);
    wb_ack = 1'b0;
    check("stray_valid", {31'h0, rsp_valid}, 32'h0);
    check("stray_cyc",   {31'h0, wb_cyc},    32'h0);
    check("stray_ready", {31'h0, req_ready}, 32'h1);
    do_txn(1'b0, 32'hFFFF_FFFC, 4'h1, 32'h0, TO - 1, 32'h0BAD_F00D);
    do_txn(1'b1, 32'h0000_0008, 4'hC, 32'h1111_2222, TO, 32'h0);

    // Reset in the middle of a bus cycle.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = 32'h0000_0400;
    req_sel   = 4'hF;
    @(negedge clk_1x);
    req_valid = 1'b0;
    @(negedge clk_1x);
    check("mid_cyc_before", {31'h0, wb_cyc}, 32'h1);
    rst = 1'b1;
    @(negedge clk_1x);
    rst = 1'b0;
    check("mid_cyc",   {31'h0, wb_cyc},    32'h0);
    check("mid_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk_1x);
    check("mid_valid2", {31'h0, rsp_valid}, 32'h0);
    check("mid_cyc2",   {31'h0, wb_cyc},    32'h0);

    // Interrupt register.
    irq_prev = 4'h0;
    for (int i = 0; i < 10; i++) begin
      irq_v = (i == 0) ? 4'b1010 : (i == 1) ? 4'b0101 : 4'($urandom);
      set_irq(irq_v);
      #1;
      check("irq_hold", {28'h0, irq_out}, {28'h0, irq_prev});
      @(negedge clk_1x);
      check("irq_next", {28'h0, irq_out}, {28'h0, irq_v});
      $display("irq in=%b out=%b", irq_v, irq_out);
      irq_prev = irq_v;
    end

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom), $urandom, 4'($urandom), $urandom,
             int'($urandom_range(0, TO + 3)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk_1x);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/a2o_wb.md
Name: a2o_wb

Overview:
- Bus/interrupt front end of the A2O core wrapper.
- Converts the core's single-outstanding 32-bit load/store request port into a Wishbone classic (B3, non-pipelined) master for the LiteX SoC bus.
- Registers the four SoC interrupt lines toward the core.
- Sits between the A2O core and the LiteX interconnect; the core itself is outside this block.

Parameters:
- TIMEOUT, 255: Wishbone cycles without ack before a transaction is abandoned with an error response; 0 disables the timeout.

Ports:
- clk_1x  in  1  sole functional clock; all state is clocked on its rising edge.
- clk_2x  in  1  pin-compatibility only; unused, no logic attached.
- rst  in  1  synchronous, active-high reset.
- timerInterrupt  in  1  SoC timer interrupt, level.
- externalInterrupt  in  1  SoC machine external interrupt, level.
- softwareInterrupt  in  1  SoC software interrupt, level.
- externalInterruptS  in  1  SoC supervisor external interrupt, level.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_adr  in  32  core byte address.
- req_sel  in  4  byte enables.
- req_dat  in  32  store data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_dat  out  32  load data.
- rsp_err  out  1  response is a timeout error.
- irq_out  out  4  registered interrupts {externalInterruptS, softwareInterrupt, externalInterrupt, timerInterrupt}.
- wb_stb  out  1  Wishbone strobe.
- wb_cyc  out  1  Wishbone cycle.
- wb_adr  out  32  Wishbone word address.
- wb_we  out  1  Wishbone write enable.
- wb_sel  out  4  Wishbone byte selects.
- wb_datw  out  32  Wishbone write data.
- wb_ack  in  1  Wishbone acknowledge.
- wb_datr  in  32  Wishbone read data.

Behaviour:
- Reset: next cycle, state is IDLE and every output is 0 except req_ready, which is 1. Timeout counter is cleared.
- Reset asserted mid-transaction drops wb_cyc/wb_stb on the next edge and generates no response.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch the request and go to BUS. Next cycle: wb_cyc=wb_stb=1, wb_adr={2'b00, req_adr[31:2]}, wb_we=req_we, wb_sel=req_sel.
  - wb_datw=req_dat for stores; 0 for loads.
- BUS:
  - req_ready=0; all Wishbone outputs held stable.
  - Counter increments each cycle.
  - On wb_ack=1: capture wb_datr into rsp_dat (loads only; stores give rsp_dat=0), rsp_err=0, deassert wb_cyc/wb_stb on the next edge, go to RESP.
  - If the counter reaches TIMEOUT with no ack (TIMEOUT≠0): deassert the bus, rsp_dat=0, rsp_err=1, go to RESP.
  - An ack arriving in the same cycle the timeout expires wins; the response is normal.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Earliest next request accept is the cycle after RESP.
  - Minimum latency: request accepted at edge N, cyc/stb high from N+1; ack seen at N+1 gives rsp_valid high during N+2→N+3.
- wb_ack while not in BUS is ignored.
- req_valid while req_ready=0 is ignored; the core must hold it.
- irq_out: one register stage, so 1-cycle latency; no edge detection.
- wb_adr upper two bits are always 0. Address wrap is not possible.

Decomposition:
- Shared package a2o_wb_pkg holds:
  - state enum (IDLE, BUS, RESP);
  - irq bit indices TMR=0, EXT=1, SW=2, EXTS=3;
  - default TIMEOUT constant.
- One natural sub-module: a2o_wb_irq_sync (4-bit interrupt register). The FSM and datapath stay in a2o_wb.

Test Plan:
- Reset, then drive req_valid=0: all bus outputs 0, req_ready=1, irq_out=0; clk_2x toggling or stuck has no effect.
- Load: req_adr=0x40000010, sel=0xF; slave acks 2 cycles after stb with wb_datr=0xDEADBEEF → wb_adr=0x10000004, wb_we=0, one rsp_valid with rsp_dat=0xDEADBEEF, rsp_err=0.
- Store: req_adr=0x00000104, sel=0x3, dat=0x0000A55A; immediate ack → wb_we=1, wb_sel=0x3, wb_datw=0x0000A55A, wb_adr=0x41, rsp_valid with rsp_err=0.
- Timeout with TIMEOUT=8 and no ack: stb high exactly 8 cycles, then rsp_valid=1, rsp_err=1. A subsequent request then completes normally; a stray late ack is ignored.
- Assert rst during BUS: wb_cyc=0 the next cycle, no rsp_valid, req_ready=1.
- Drive interrupts 4'b1010, then 4'b0101: irq_out follows one cycle later with the same values.
